apb2axi_axi_rsp_gen: RTL and testbench
======================================

APB2AXI_AXI_RSP_GEN -- requirements
Module: apb2axi_axi_rsp_gen

Interface
REQ-001 Parameter: RD_LAT, default 2, cycles from AR handshake to first rvalid (1..15).
REQ-002 aclk  in  1  clock, all logic on rising edge; single clock domain.
REQ-003 aresetn  in  1  reset, synchronous, active-low.
REQ-004 arid/araddr/arlen/arvalid  in  TAG_W/AXI_ADDR_W/8/1  read address; arready out 1.
REQ-005 awid/awaddr/awlen/awvalid  in  TAG_W/AXI_ADDR_W/8/1  write address; awready out 1.
REQ-006 wdata/wlast/wvalid  in  AXI_DATA_W/1/1  write data; wready out 1.
REQ-007 rid/rdata/rresp/rlast/rvalid  out  TAG_W/AXI_DATA_W/2/1/1  read data; rready in 1.
REQ-008 bid/bresp/bvalid  out  TAG_W/2/1  write response; bready in 1.
REQ-009 cfg_err_en  in  1  enables error injection.
REQ-010 cfg_err_beat  in  8  read beat index receiving injected error.
REQ-011 cfg_err_resp  in  2  injected response code (axi_resp_e).

Function
REQ-012 Read FSM states R_IDLE, R_WAIT, R_DATA; one outstanding read.
REQ-013 arready = 1 only in R_IDLE; AR handshake latches arid, araddr, arlen, clears beat counter, enters R_WAIT.
REQ-014 R_WAIT counts RD_LAT-1 cycles then enters R_DATA; first rvalid asserts exactly RD_LAT cycles after AR handshake.
REQ-015 R_DATA: rvalid held 1; rid/rdata/rresp/rlast stable while rvalid && !rready.
REQ-016 Beat advances only on rvalid && rready; beats issued = arlen+1; rlast = 1 only when beat counter == arlen.
REQ-017 rdata = 32-bit word (araddr[31:0] + beat_idx*(AXI_DATA_W/8)) replicated AXI_DATA_W/32 times; arithmetic modulo 2^32.
REQ-018 rresp = cfg_err_resp when cfg_err_en && beat_idx == cfg_err_beat, else OKAY; cfg_err_beat > arlen injects nothing.
REQ-019 Handshake on rlast beat returns to R_IDLE; arready reasserts next cycle (no back-to-back AR accept in same cycle).
REQ-020 Write FSM states W_IDLE, W_DATA, W_RESP; one outstanding write.
REQ-021 awready = 1 only in W_IDLE; AW handshake latches awid, awlen, clears W beat counter, enters W_DATA.
REQ-022 wready = 1 only in W_DATA; wdata discarded; each wvalid && wready increments W beat counter.
REQ-023 W beat with wlast=1, or beat counter == awlen, ends burst and enters W_RESP next cycle.
REQ-024 Burst length mismatch (wlast on beat != awlen, or beat awlen without wlast) -> bresp = SLVERR, overriding injection.
REQ-025 Otherwise bresp = cfg_err_resp if cfg_err_en, else OKAY.
REQ-026 W_RESP: bvalid = 1 with bid = latched awid; held stable until bready; handshake -> W_IDLE.
REQ-027 Read and write paths fully independent; simultaneous AR and AW handshakes in same cycle both accepted.
REQ-028 cfg_* sampled per beat (read) or at burst end (write); no latching required.

Reset
REQ-029 aresetn=0 on a clock edge: both FSMs -> IDLE, all counters and latched fields -> 0.
REQ-030 Output values during/after reset: rvalid, bvalid, wready = 0; arready, awready = 1; rid, rdata, rresp, rlast, bid, bresp = 0.
REQ-031 Reset mid-burst aborts transaction; no residual R/B beat issued after reset release.

Structure
REQ-032 TAG_W, AXI_ADDR_W, AXI_DATA_W, axi_resp_e from apb2axi_pkg; read/write FSM state enums declared in apb2axi_pkg.
REQ-033 No sub-modules; read and write engines as two always_ff blocks in one module.

Verification
REQ-034 AR id=3 addr=0x1000 len=3, rready=1, RD_LAT=2 -> rvalid 2 cycles after AR; 4 beats rdata words 0x1000,0x1008,0x1010,0x1018 (64-bit data), rlast on beat 3, rresp OKAY.
REQ-035 Same read, rready toggled 1/0 each cycle -> every R field stable while stalled, beat count 4, no skipped beats.
REQ-036 cfg_err_en=1, cfg_err_beat=2, cfg_err_resp=SLVERR, len=3 -> beats 0,1,3 OKAY, beat 2 SLVERR.
REQ-037 AW id=5 len=1, two W beats wlast on second, bready=1 -> bid=5, bresp OKAY one cycle after last W; len=1 with wlast on first beat -> SLVERR.
REQ-038 Concurrent AR len=7 and AW len=0 same cycle -> both accepted, R and B complete independently with correct ids.
REQ-039 aresetn low during R_DATA beat 2 -> next cycle rvalid=0, arready=1; new AR after release completes normally.

Source files
------------

// File: rtl/apb2axi_pkg.sv
// Shared AXI widths, response codes and engine state encodings for the apb2axi
// response generator slice.
package apb2axi_pkg;

   localparam int TAG_W          = 4;
   localparam int AXI_ADDR_W     = 32;
   localparam int AXI_DATA_W     = 64;
   localparam int AXI_BYTES      = AXI_DATA_W / 8;
   localparam int WORDS_PER_BEAT = AXI_DATA_W / 32;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } axi_resp_e;

   typedef enum logic [1:0] {
      R_IDLE,
      R_WAIT,
      R_DATA
   } rd_state_e;

   typedef enum logic [1:0] {
      W_IDLE,
      W_DATA,
      W_RESP
   } wr_state_e;

   // Synthetic read word for a beat: base address advanced by one bus width per beat.
   function automatic logic [31:0] beat_word(input logic [31:0] base, input logic [7:0] beat);
      return base + 32'(beat) * 32'(AXI_BYTES);
   endfunction

endpackage

// File: rtl/apb2axi_axi_rsp_gen.sv
// AXI slave responder: returns address-pattern read data after a fixed latency and
// acknowledges write bursts, with optional response-code error injection.
module apb2axi_axi_rsp_gen
   import apb2axi_pkg::*;
#(
   parameter int RD_LAT = 2
)
(
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [TAG_W-1:0]      arid,
   input  logic [AXI_ADDR_W-1:0] araddr,
   input  logic [7:0]            arlen,
   input  logic                  arvalid,
   output logic                  arready,
   input  logic [TAG_W-1:0]      awid,
   input  logic [AXI_ADDR_W-1:0] awaddr,
   input  logic [7:0]            awlen,
   input  logic                  awvalid,
   output logic                  awready,
   input  logic [AXI_DATA_W-1:0] wdata,
   input  logic                  wlast,
   input  logic                  wvalid,
   output logic                  wready,
   output logic [TAG_W-1:0]      rid,
   output logic [AXI_DATA_W-1:0] rdata,
   output axi_resp_e             rresp,
   output logic                  rlast,
   output logic                  rvalid,
   input  logic                  rready,
   output logic [TAG_W-1:0]      bid,
   output axi_resp_e             bresp,
   output logic                  bvalid,
   input  logic                  bready,
   input  logic                  cfg_err_en,
   input  logic [7:0]            cfg_err_beat,
   input  axi_resp_e             cfg_err_resp
);

   rd_state_e             r_state_reg, r_state_next;
   logic [3:0]            r_wait_reg, r_wait_next;
   logic [7:0]            r_beat_reg, r_beat_next;
   logic [TAG_W-1:0]      r_id_reg, r_id_next;
   logic [AXI_ADDR_W-1:0] r_addr_reg, r_addr_next;
   logic [7:0]            r_len_reg, r_len_next;
   logic [31:0]           r_word;

   wr_state_e             w_state_reg, w_state_next;
   logic [7:0]            w_beat_reg, w_beat_next;
   logic [TAG_W-1:0]      w_id_reg, w_id_next;
   logic [7:0]            w_len_reg, w_len_next;
   axi_resp_e             b_resp_reg, b_resp_next;

   // Write address and payload are accepted but never stored.
   logic                  unused_inputs;
   assign unused_inputs = ^{awaddr, wdata};

   // ---------------- read engine ----------------
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_state_reg <= R_IDLE;
         r_wait_reg  <= '0;
         r_beat_reg  <= '0;
         r_id_reg    <= '0;
         r_addr_reg  <= '0;
         r_len_reg   <= '0;
      end else begin
         r_state_reg <= r_state_next;
         r_wait_reg  <= r_wait_next;
         r_beat_reg  <= r_beat_next;
         r_id_reg    <= r_id_next;
         r_addr_reg  <= r_addr_next;
         r_len_reg   <= r_len_next;
      end
   end

   always_comb begin
      r_state_next = r_state_reg;
      r_wait_next  = r_wait_reg;
      r_beat_next  = r_beat_reg;
      r_id_next    = r_id_reg;
      r_addr_next  = r_addr_reg;
      r_len_next   = r_len_reg;
      case (r_state_reg)
         R_IDLE: begin
            if (arvalid) begin
               r_id_next    = arid;
               r_addr_next  = araddr;
               r_len_next   = arlen;
               r_beat_next  = '0;
               r_wait_next  = '0;
               r_state_next = R_WAIT;
            end
         end
         R_WAIT: begin
            // The handshake cycle itself counts as the first latency cycle.
            if (r_wait_reg == 4'(RD_LAT - 1)) begin
               r_state_next = R_DATA;
            end else begin
               r_wait_next = r_wait_reg + 4'd1;
            end
         end
         R_DATA: begin
            if (rready) begin
               if (r_beat_reg == r_len_reg) begin
                  r_state_next = R_IDLE;
               end else begin
                  r_beat_next = r_beat_reg + 8'd1;
               end
            end
         end
         default: r_state_next = R_IDLE;
      endcase
   end

   assign arready = (r_state_reg == R_IDLE);
   assign rvalid  = (r_state_reg == R_DATA);
   assign rid     = r_id_reg;
   assign rlast   = rvalid && (r_beat_reg == r_len_reg);
   assign rresp   = (rvalid && cfg_err_en && (r_beat_reg == cfg_err_beat)) ? cfg_err_resp : OKAY;
   assign r_word  = beat_word(r_addr_reg[31:0], r_beat_reg);

   genvar gi;
   generate
      for (gi = 0; gi < WORDS_PER_BEAT; gi++) begin : g_lane
         assign rdata[gi*32 +: 32] = r_word;
      end
   endgenerate

   // ---------------- write engine ----------------
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         w_state_reg <= W_IDLE;
         w_beat_reg  <= '0;
         w_id_reg    <= '0;
         w_len_reg   <= '0;
         b_resp_reg  <= OKAY;
      end else begin
         w_state_reg <= w_state_next;
         w_beat_reg  <= w_beat_next;
         w_id_reg    <= w_id_next;
         w_len_reg   <= w_len_next;
         b_resp_reg  <= b_resp_next;
      end
   end

   always_comb begin
      w_state_next = w_state_reg;
      w_beat_next  = w_beat_reg;
      w_id_next    = w_id_reg;
      w_len_next   = w_len_reg;
      b_resp_next  = b_resp_reg;
      case (w_state_reg)
         W_IDLE: begin
            if (awvalid) begin
               w_id_next    = awid;
               w_len_next   = awlen;
               w_beat_next  = '0;
               w_state_next = W_DATA;
            end
         end
         W_DATA: begin
            if (wvalid) begin
               w_beat_next = w_beat_reg + 8'd1;
               if (wlast || (w_beat_reg == w_len_reg)) begin
                  w_state_next = W_RESP;
                  // A burst is well formed only when wlast lands exactly on beat awlen.
                  if (wlast != (w_beat_reg == w_len_reg)) begin
                     b_resp_next = SLVERR;
                  end else if (cfg_err_en) begin
                     b_resp_next = cfg_err_resp;
                  end else begin
                     b_resp_next = OKAY;
                  end
               end
            end
         end
         W_RESP: begin
            if (bready) begin
               w_state_next = W_IDLE;
            end
         end
         default: w_state_next = W_IDLE;
      endcase
   end

   assign awready = (w_state_reg == W_IDLE);
   assign wready  = (w_state_reg == W_DATA);
   assign bvalid  = (w_state_reg == W_RESP);
   assign bid     = w_id_reg;
   assign bresp   = b_resp_reg;

endmodule

// File: tb/tb_apb2axi_axi_rsp_gen.sv
// Self-checking bench for apb2axi_axi_rsp_gen: directed and randomized read/write
// bursts compared against a transaction-level reference model.
module tb_apb2axi_axi_rsp_gen;
   import apb2axi_pkg::*;

   localparam int RD_LAT = 2;

   logic                  aclk = 1'b0;
   logic                  aresetn;
   logic [TAG_W-1:0]      arid;
   logic [AXI_ADDR_W-1:0] araddr;
   logic [7:0]            arlen;
   logic                  arvalid;
   logic                  arready;
   logic [TAG_W-1:0]      awid;
   logic [AXI_ADDR_W-1:0] awaddr;
   logic [7:0]            awlen;
   logic                  awvalid;
   logic                  awready;
   logic [AXI_DATA_W-1:0] wdata;
   logic                  wlast;
   logic                  wvalid;
   logic                  wready;
   logic [TAG_W-1:0]      rid;
   logic [AXI_DATA_W-1:0] rdata;
   axi_resp_e             rresp;
   logic                  rlast;
   logic                  rvalid;
   logic                  rready;
   logic [TAG_W-1:0]      bid;
   axi_resp_e             bresp;
   logic                  bvalid;
   logic                  bready;
   logic                  cfg_err_en;
   logic [7:0]            cfg_err_beat;
   axi_resp_e             cfg_err_resp;

   int checks = 0;
   int errors = 0;

   apb2axi_axi_rsp_gen #(.RD_LAT(RD_LAT)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .cfg_err_en(cfg_err_en), .cfg_err_beat(cfg_err_beat), .cfg_err_resp(cfg_err_resp)
   );

   always #5 aclk = ~aclk;

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   // Reference: 32-bit word addr + beat*bytes_per_beat (mod 2^32) in every lane.
   function automatic logic [AXI_DATA_W-1:0] exp_rdata(input logic [31:0] addr, input int beat);
      logic [31:0]           w;
      logic [AXI_DATA_W-1:0] d;
      w = addr + 32'(beat * (AXI_DATA_W / 8));
      for (int i = 0; i < AXI_DATA_W / 32; i++) d[i*32 +: 32] = w;
      return d;
   endfunction

   function automatic axi_resp_e exp_rresp(input int beat);
      if (cfg_err_en && (beat == int'(cfg_err_beat))) return cfg_err_resp;
      return OKAY;
   endfunction

   function automatic axi_resp_e exp_bresp(input int len, input int wlast_beat);
      if (wlast_beat != len) return SLVERR;
      if (cfg_err_en) return cfg_err_resp;
      return OKAY;
   endfunction

   // rmode: 0 = rready always high, 1 = toggling 1/0, 2 = random
   task automatic run_read(input logic [TAG_W-1:0] id, input logic [31:0] addr, input int len,
                           input int rmode);
      int lat, beat, guard;
      logic toggle, stalled, bad;
      logic [TAG_W+AXI_DATA_W+2:0] saved;
      arid = id; araddr = addr; arlen = 8'(len); arvalid = 1'b1;
      guard = 0;
      while (!arready && guard < 20) begin tick(); guard++; end
      checks++;
      if (arready !== 1'b1) begin
         $display("FAIL ar_accept arready=%0b expected 1", arready); errors++;
      end
      tick();
      arvalid = 1'b0;
      lat = 0;
      while (!rvalid && lat < 20) begin tick(); lat++; end
      checks++;
      if (lat != RD_LAT) begin
         $display("FAIL r_latency got %0d cycles expected %0d", lat, RD_LAT); errors++;
      end
      beat = 0; guard = 0; toggle = 1'b1; stalled = 1'b0; saved = '0;
      while (beat <= len && guard < 400) begin
         case (rmode)
            0: rready = 1'b1;
            1: begin rready = toggle; toggle = ~toggle; end
            default: rready = 1'($urandom_range(0, 1));
         endcase
         checks++;
         bad = (rvalid !== 1'b1) || (rid !== id) || (rdata !== exp_rdata(addr, beat)) ||
               (rresp !== exp_rresp(beat)) || (rlast !== (beat == len));
         if (bad) begin
            $display("FAIL r_beat %0d got rvalid=%0b rid=%0h rdata=%h rresp=%0d rlast=%0b expected rvalid=1 rid=%0h rdata=%h rresp=%0d rlast=%0b",
                     beat, rvalid, rid, rdata, rresp, rlast, id, exp_rdata(addr, beat),
                     exp_rresp(beat), (beat == len));
            errors++;
            rready = 1'b0;
            break;
         end
         if (stalled) begin
            checks++;
            if ({rid, rdata, rresp, rlast} !== saved) begin
               $display("FAIL r_stable beat %0d got %h expected %h", beat,
                        {rid, rdata, rresp, rlast}, saved);
               errors++;
            end
         end
         stalled = ~rready;
         saved = {rid, rdata, rresp, rlast};
         tick();
         guard++;
         if (rready) beat++;
      end
      rready = 1'b0;
      checks++;
      if (rvalid !== 1'b0 || arready !== 1'b1) begin
         $display("FAIL r_end got rvalid=%0b arready=%0b expected rvalid=0 arready=1", rvalid, arready);
         errors++;
      end
      $display("read  id=%0h addr=%h len=%0d mode=%0d beats=%0d", id, addr, len, rmode, beat);
   endtask

   // wlast_beat: index of the beat carrying wlast (-1 or > len means never)
   task automatic run_write(input logic [TAG_W-1:0] id, input int len, input int wlast_beat);
      int last_idx, guard, hold;
      axi_resp_e exp;
      awid = id; awaddr = $urandom; awlen = 8'(len); awvalid = 1'b1;
      guard = 0;
      while (!awready && guard < 20) begin tick(); guard++; end
      checks++;
      if (awready !== 1'b1) begin
         $display("FAIL aw_accept awready=%0b expected 1", awready); errors++;
      end
      tick();
      awvalid = 1'b0;
      last_idx = (wlast_beat >= 0 && wlast_beat < len) ? wlast_beat : len;
      exp = exp_bresp(len, wlast_beat);
      for (int b = 0; b <= last_idx; b++) begin
         if ($urandom_range(0, 3) == 0) begin wvalid = 1'b0; tick(); end
         wvalid = 1'b1; wdata = {$urandom, $urandom}; wlast = (b == wlast_beat);
         checks++;
         if (wready !== 1'b1) begin
            $display("FAIL w_ready beat %0d got %0b expected 1", b, wready); errors++;
         end
         tick();
      end
      wvalid = 1'b0; wlast = 1'b0;
      checks++;
      if (bvalid !== 1'b1 || bid !== id || bresp !== exp || wready !== 1'b0) begin
         $display("FAIL b_resp got bvalid=%0b bid=%0h bresp=%0d wready=%0b expected bvalid=1 bid=%0h bresp=%0d wready=0",
                  bvalid, bid, bresp, wready, id, exp);
         errors++;
      end
      hold = $urandom_range(0, 3);
      for (int i = 0; i < hold; i++) begin
         tick();
         checks++;
         if (bvalid !== 1'b1 || bid !== id || bresp !== exp) begin
            $display("FAIL b_stable got bvalid=%0b bid=%0h bresp=%0d expected 1 %0h %0d",
                     bvalid, bid, bresp, id, exp);
            errors++;
         end
      end
      bready = 1'b1;
      tick();
      bready = 1'b0;
      checks++;
      if (bvalid !== 1'b0 || awready !== 1'b1) begin
         $display("FAIL b_end got bvalid=%0b awready=%0b expected 0 1", bvalid, awready); errors++;
      end
      $display("write id=%0h len=%0d wlast_beat=%0d bresp=%0d", id, len, wlast_beat, exp);
   endtask

   task automatic set_cfg(input logic en, input int beat, input axi_resp_e resp);
      cfg_err_en = en; cfg_err_beat = 8'(beat); cfg_err_resp = resp;
   endtask

   task automatic test_reset();
      aresetn = 1'b0;
      tick(); tick();
      checks++;
      if (rvalid !== 1'b0 || bvalid !== 1'b0 || wready !== 1'b0 || arready !== 1'b1 ||
          awready !== 1'b1) begin
         $display("FAIL reset_hs got rvalid=%0b bvalid=%0b wready=%0b arready=%0b awready=%0b expected 0 0 0 1 1",
                  rvalid, bvalid, wready, arready, awready);
         errors++;
      end
      checks++;
      if (rid !== '0 || rdata !== '0 || rresp !== OKAY || rlast !== 1'b0 || bid !== '0 ||
          bresp !== OKAY) begin
         $display("FAIL reset_data got rid=%0h rdata=%h rresp=%0d rlast=%0b bid=%0h bresp=%0d expected all 0",
                  rid, rdata, rresp, rlast, bid, bresp);
         errors++;
      end
      aresetn = 1'b1;
      tick();
      $display("reset checked");
   endtask

   task automatic test_read_basic();
      set_cfg(1'b0, 0, OKAY);
      run_read(4'd3, 32'h0000_1000, 3, 0);
      run_read(4'd9, 32'hFFFF_FFF0, 3, 0);
   endtask

   task automatic test_read_stall();
      set_cfg(1'b0, 0, OKAY);
      run_read(4'd3, 32'h0000_1000, 3, 1);
   endtask

   task automatic test_err_inject();
      set_cfg(1'b1, 2, SLVERR);
      run_read(4'd3, 32'h0000_1000, 3, 0);
      set_cfg(1'b1, 9, DECERR);
      run_read(4'd6, 32'h0000_2000, 3, 2);
      set_cfg(1'b1, 0, EXOKAY);
      run_read(4'd7, 32'h0000_3000, 0, 0);
      set_cfg(1'b0, 0, OKAY);
   endtask

   task automatic test_write_basic();
      set_cfg(1'b0, 0, OKAY);
      run_write(4'd5, 1, 1);
      run_write(4'd5, 1, 0);
      run_write(4'd2, 2, -1);
      run_write(4'd4, 0, 0);
      set_cfg(1'b1, 0, DECERR);
      run_write(4'd8, 3, 3);
      run_write(4'd9, 3, 1);
      set_cfg(1'b0, 0, OKAY);
   endtask

   task automatic test_concurrent();
      int r_beats, b_seen, guard;
      set_cfg(1'b0, 0, OKAY);
      arid = 4'hA; araddr = 32'h0000_4000; arlen = 8'd7; arvalid = 1'b1;
      awid = 4'hC; awaddr = 32'h0000_8000; awlen = 8'd0; awvalid = 1'b1;
      checks++;
      if (arready !== 1'b1 || awready !== 1'b1) begin
         $display("FAIL conc_accept got arready=%0b awready=%0b expected 1 1", arready, awready);
         errors++;
      end
      tick();
      arvalid = 1'b0; awvalid = 1'b0;
      wvalid = 1'b1; wlast = 1'b1; rready = 1'b1; bready = 1'b1;
      r_beats = 0; b_seen = 0; guard = 0;
      while ((r_beats < 8 || b_seen < 1) && guard < 60) begin
         if (rvalid) begin
            checks++;
            if (rid !== 4'hA || rdata !== exp_rdata(32'h0000_4000, r_beats) ||
                rlast !== (r_beats == 7)) begin
               $display("FAIL conc_r beat %0d got rid=%0h rdata=%h rlast=%0b expected %0h %h %0b",
                        r_beats, rid, rdata, rlast, 4'hA, exp_rdata(32'h0000_4000, r_beats),
                        (r_beats == 7));
               errors++;
            end
            r_beats++;
         end
         if (bvalid) begin
            checks++;
            if (bid !== 4'hC || bresp !== OKAY) begin
               $display("FAIL conc_b got bid=%0h bresp=%0d expected c 0", bid, bresp); errors++;
            end
            b_seen++;
         end
         tick();
         wvalid = 1'b0; wlast = 1'b0;
         guard++;
      end
      rready = 1'b0; bready = 1'b0;
      checks++;
      if (r_beats != 8 || b_seen != 1) begin
         $display("FAIL conc_count got r=%0d b=%0d expected 8 1", r_beats, b_seen); errors++;
      end
      $display("concurrent r_beats=%0d b_seen=%0d", r_beats, b_seen);
   endtask

   task automatic test_reset_mid();
      int beat, guard;
      set_cfg(1'b0, 0, OKAY);
      arid = 4'h1; araddr = 32'h0000_5000; arlen = 8'd5; arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      guard = 0;
      while (!rvalid && guard < 20) begin tick(); guard++; end
      rready = 1'b1;
      beat = 0;
      while (beat < 2 && guard < 40) begin
         tick(); guard++;
         beat++;
      end
      checks++;
      if (rvalid !== 1'b1 || rdata !== exp_rdata(32'h0000_5000, 2)) begin
         $display("FAIL mid_beat2 got rvalid=%0b rdata=%h expected 1 %h", rvalid, rdata,
                  exp_rdata(32'h0000_5000, 2));
         errors++;
      end
      rready = 1'b0;
      aresetn = 1'b0;
      tick();
      checks++;
      if (rvalid !== 1'b0 || arready !== 1'b1 || rid !== '0) begin
         $display("FAIL mid_reset got rvalid=%0b arready=%0b rid=%0h expected 0 1 0", rvalid, arready, rid);
         errors++;
      end
      aresetn = 1'b1;
      rready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (rvalid !== 1'b0 || bvalid !== 1'b0) begin
            $display("FAIL mid_residual cycle %0d got rvalid=%0b bvalid=%0b expected 0 0", i, rvalid, bvalid);
            errors++;
         end
      end
      rready = 1'b0;
      $display("reset mid-burst checked");
      run_read(4'h2, 32'h0000_6000, 2, 0);
   endtask

   task automatic test_random();
      int len;
      for (int n = 0; n < 12; n++) begin
         len = $urandom_range(0, 7);
         set_cfg(1'($urandom_range(0, 1)), $urandom_range(0, len + 1),
                 axi_resp_e'(2'($urandom_range(0, 3))));
         run_read(4'($urandom), $urandom, len, 2);
         len = $urandom_range(0, 5);
         run_write(4'($urandom), len, ($urandom_range(0, 3) == 0) ? $urandom_range(0, len + 1) - 1 : len);
      end
      set_cfg(1'b0, 0, OKAY);
   endtask

   initial begin
      aresetn = 1'b0;
      arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0;
      awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
      wdata = '0; wlast = 1'b0; wvalid = 1'b0;
      rready = 1'b0; bready = 1'b0;
      set_cfg(1'b0, 0, OKAY);
      test_reset();
      test_read_basic();
      test_read_stall();
      test_err_inject();
      test_write_basic();
      test_concurrent();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
